bus_memory_responder: RTL and testbench

Memory-side responder for the `top8227` CPU bus. It decodes the 16-bit address the core drives and answers reads with a registered data byte on the core's data input. It captures core writes into a small RAM and logs every write into a trace FIFO for the bench. It sits beside `top8227` in simulation and FPGA bring-up, replacing hand-driven `dataBusInput` stimulus with a real memory image plus fixed interrupt and reset vectors.

---
 rtl/bus_memory_responder.sv | 163 ++++++++++++++++
 tb/tb_bus_memory_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_memory_responder.sv
// Memory-side responder for the top8227 CPU bus: RAM, fixed vectors and a registered read port,
// plus a small FIFO that logs every core write for inspection by the bench.
module bus_memory_responder #(
  parameter int unsigned RAM_DEPTH    = 512,
  parameter logic [15:0] RESET_VECTOR = 16'hCCDD,
  parameter logic [15:0] NMI_VECTOR   = 16'h0200,
  parameter logic [15:0] IRQ_VECTOR   = 16'h0300,
  parameter logic [7:0]  FILL_BYTE    = 8'hEA
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [7:0]  AddressBusHigh,
  input  logic [7:0]  AddressBusLow,
  input  logic        readNotWrite,
  input  logic [7:0]  busDataFromCpu,
  output logic [7:0]  busDataToCpu,
  input  logic        loadEnable,
  input  logic [15:0] loadAddress,
  input  logic [7:0]  loadData,
  output logic        traceValid,
  output logic [15:0] traceAddress,
  output logic [7:0]  traceData,
  input  logic        tracePop,
  output logic        traceOverflow
);

  localparam int unsigned RamAw      = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int unsigned TraceDepth = 4;

  // ---------------------------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------------------------
  logic [15:0]      core_addr;
  logic             core_in_ram;
  logic             load_in_ram;
  logic [RamAw-1:0] core_idx;
  logic [RamAw-1:0] load_idx;
  logic             core_wr;

  assign core_addr   = {AddressBusHigh, AddressBusLow};
  assign core_in_ram = ({16'd0, core_addr} < RAM_DEPTH);
  assign load_in_ram = ({16'd0, loadAddress} < RAM_DEPTH);
  assign core_idx    = core_addr[RamAw-1:0];
  assign load_idx    = loadAddress[RamAw-1:0];
  assign core_wr     = ~readNotWrite;

  // ---------------------------------------------------------------------------------------------
  // RAM (not reset; contents survive nrst)
  // ---------------------------------------------------------------------------------------------
  logic [7:0] ram_q [RAM_DEPTH];
  logic       ram_load_we;
  logic       ram_core_we;

  assign ram_load_we = loadEnable & load_in_ram;
  // Preload wins a same-address collision with a core write.
  assign ram_core_we = core_wr & core_in_ram & ~(ram_load_we & (load_idx == core_idx));

  always_ff @(posedge clk) begin
    if (ram_core_we) begin
      ram_q[core_idx] <= busDataFromCpu;
    end
    if (ram_load_we) begin
      ram_q[load_idx] <= loadData;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------------------------
  logic [7:0] vector_byte;
  logic [7:0] read_byte;
  logic [7:0] rd_data_q;

  always_comb begin
    vector_byte = FILL_BYTE;
    case (core_addr)
      16'hFFFA: vector_byte = NMI_VECTOR[7:0];
      16'hFFFB: vector_byte = NMI_VECTOR[15:8];
      16'hFFFC: vector_byte = RESET_VECTOR[7:0];
      16'hFFFD: vector_byte = RESET_VECTOR[15:8];
      16'hFFFE: vector_byte = IRQ_VECTOR[7:0];
      16'hFFFF: vector_byte = IRQ_VECTOR[15:8];
      default:  vector_byte = FILL_BYTE;
    endcase
  end

  // RAM is read before this edge's writes land, so a same-cycle preload is not bypassed.
  assign read_byte = core_in_ram ? ram_q[core_idx] : vector_byte;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_data_q <= 8'h00;
    end else if (readNotWrite) begin
      rd_data_q <= read_byte;
    end
  end

  assign busDataToCpu = rd_data_q;

  // ---------------------------------------------------------------------------------------------
  // Write trace FIFO
  // ---------------------------------------------------------------------------------------------
  logic [23:0] trace_mem_q [TraceDepth];
  logic [1:0]  head_q, head_d;
  logic [1:0]  tail_q, tail_d;
  logic [2:0]  count_q, count_d;
  logic        overflow_q, overflow_d;
  logic        trace_full;
  logic        trace_empty;
  logic        pop_ok;
  logic        push_ok;
  logic        push_drop;

  assign trace_full  = (count_q == 3'(TraceDepth));
  assign trace_empty = (count_q == 3'd0);
  assign pop_ok      = tracePop & ~trace_empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign push_ok     = core_wr & (~trace_full | pop_ok);
  assign push_drop   = core_wr & trace_full & ~pop_ok;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q | push_drop;
    if (pop_ok) begin
      head_d = head_q + 2'd1;
    end
    if (push_ok) begin
      tail_d = tail_q + 2'd1;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      head_q     <= 2'd0;
      tail_q     <= 2'd0;
      count_q    <= 3'd0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      trace_mem_q[tail_q] <= {core_addr, busDataFromCpu};
    end
  end

  assign traceValid                = ~trace_empty;
  assign {traceAddress, traceData} = trace_mem_q[head_q];
  assign traceOverflow             = overflow_q;

endmodule

// File: tb/tb_bus_memory_responder.sv
// Self-checking bench for bus_memory_responder: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue/array reference model.
module tb_bus_memory_responder;

  localparam int RAM_DEPTH = 512;

  logic        clk = 1'b0;
  logic        nrst;
  logic [7:0]  AddressBusHigh, AddressBusLow;
  logic        readNotWrite;
  logic [7:0]  busDataFromCpu;
  logic [7:0]  busDataToCpu;
  logic        loadEnable;
  logic [15:0] loadAddress;
  logic [7:0]  loadData;
  logic        traceValid;
  logic [15:0] traceAddress;
  logic [7:0]  traceData;
  logic        tracePop;
  logic        traceOverflow;

  int checks = 0;
  int passes = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  bus_memory_responder #(
    .RAM_DEPTH    (RAM_DEPTH),
    .RESET_VECTOR (16'hCCDD),
    .NMI_VECTOR   (16'h0200),
    .IRQ_VECTOR   (16'h0300),
    .FILL_BYTE    (8'hEA)
  ) dut (
    .clk            (clk),
    .nrst           (nrst),
    .AddressBusHigh (AddressBusHigh),
    .AddressBusLow  (AddressBusLow),
    .readNotWrite   (readNotWrite),
    .busDataFromCpu (busDataFromCpu),
    .busDataToCpu   (busDataToCpu),
    .loadEnable     (loadEnable),
    .loadAddress    (loadAddress),
    .loadData       (loadData),
    .traceValid     (traceValid),
    .traceAddress   (traceAddress),
    .traceData      (traceData),
    .tracePop       (tracePop),
    .traceOverflow  (traceOverflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------------------------
  // Reference model: plain memory array, expected read byte, write log queue, sticky flag
  // ---------------------------------------------------------------------------------------------
  logic [7:0]  mem_m [RAM_DEPTH];
  logic [7:0]  exp_rd;
  logic [23:0] trace_m [$];
  bit          exp_ovf;

  function automatic logic [7:0] model_read(input int a);
    if (a < RAM_DEPTH) return mem_m[a];
    case (a)
      'hFFFA:  return 8'h00;
      'hFFFB:  return 8'h02;
      'hFFFC:  return 8'hDD;
      'hFFFD:  return 8'hCC;
      'hFFFE:  return 8'h00;
      'hFFFF:  return 8'h03;
      default: return 8'hEA;
    endcase
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      exp_rd = 8'h00;
      trace_m.delete();
      exp_ovf = 1'b0;
    end else begin : model_step
      int  a;
      int  la;
      bit  pop_ok;
      a  = {AddressBusHigh, AddressBusLow};
      la = loadAddress;
      if (readNotWrite) exp_rd = model_read(a);
      pop_ok = tracePop && (trace_m.size() > 0);
      if (pop_ok) void'(trace_m.pop_front());
      if (!readNotWrite) begin
        if (trace_m.size() < 4) trace_m.push_back({a[15:0], busDataFromCpu});
        else exp_ovf = 1'b1;
        if (a < RAM_DEPTH && !(loadEnable && la == a)) mem_m[a] = busDataFromCpu;
      end
      if (loadEnable && la < RAM_DEPTH) mem_m[la] = loadData;
    end
  end

  always @(negedge clk) begin
    if (nrst && check_en) begin
      check("rd_data", 32'(busDataToCpu), 32'(exp_rd));
      check("trace_valid", 32'(traceValid), 32'(trace_m.size() != 0));
      check("overflow", 32'(traceOverflow), 32'(exp_ovf));
      if (trace_m.size() != 0) check("trace_head", 32'({traceAddress, traceData}), 32'(trace_m[0]));
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stimulus helpers: inputs change at the falling edge, one rising edge per op
  // ---------------------------------------------------------------------------------------------
  task automatic set_bus(input bit rnw, input logic [15:0] addr, input logic [7:0] wd,
                         input bit pop);
    readNotWrite   = rnw;
    {AddressBusHigh, AddressBusLow} = addr;
    busDataFromCpu = wd;
    tracePop       = pop;
    loadEnable     = 1'b0;
  endtask

  task automatic op(input bit rnw, input logic [15:0] addr, input logic [7:0] wd, input bit pop);
    set_bus(rnw, addr, wd, pop);
    @(negedge clk);
  endtask

  task automatic preload(input logic [15:0] la, input logic [7:0] ld);
    set_bus(1'b1, 16'h4000, 8'h00, 1'b0);
    loadEnable  = 1'b1;
    loadAddress = la;
    loadData    = ld;
    @(negedge clk);
    loadEnable  = 1'b0;
  endtask

  initial begin
    nrst = 1'b0;
    loadAddress = 16'h0000;
    loadData = 8'h00;
    set_bus(1'b1, 16'h4000, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    check("reset_rd", 32'(busDataToCpu), 32'h00);
    check("reset_valid", 32'(traceValid), 32'h0);
    check("reset_ovf", 32'(traceOverflow), 32'h0);
    nrst = 1'b1;
    check_en = 1'b1;

    op(1'b1, 16'hFFFC, 8'h00, 1'b0);
    check("vec_lo", 32'(busDataToCpu), 32'hDD);
    op(1'b1, 16'hFFFD, 8'h00, 1'b0);
    check("vec_hi", 32'(busDataToCpu), 32'hCC);

    preload(16'h0000, 8'hA9);
    preload(16'h0001, 8'h10);
    op(1'b1, 16'h0000, 8'h00, 1'b0);
    check("ram0", 32'(busDataToCpu), 32'hA9);
    op(1'b1, 16'h0001, 8'h00, 1'b0);
    check("ram1", 32'(busDataToCpu), 32'h10);
    op(1'b1, 16'h4000, 8'h00, 1'b0);
    check("unmapped", 32'(busDataToCpu), 32'hEA);

    op(1'b0, 16'h01FF, 8'h10, 1'b0);
    check("wr_hold", 32'(busDataToCpu), 32'hEA);
    check("push_valid", 32'(traceValid), 32'h1);
    check("push_head", 32'({traceAddress, traceData}), 32'h01FF10);
    op(1'b1, 16'h01FF, 8'h00, 1'b0);
    check("stack_rd", 32'(busDataToCpu), 32'h10);
    op(1'b1, 16'h4000, 8'h00, 1'b1);
    check("pop_empty", 32'(traceValid), 32'h0);

    // Write just past RAM is discarded but still traced.
    op(1'b0, 16'h0200, 8'h55, 1'b0);
    op(1'b1, 16'h0200, 8'h00, 1'b1);
    check("ram_edge", 32'(busDataToCpu), 32'hEA);
    check("ram_edge_pop", 32'(traceValid), 32'h0);

    for (int i = 0; i < 5; i++) op(1'b0, 16'(16'h0010 + i), 8'(i + 1), 1'b0);
    check("ovf_set", 32'(traceOverflow), 32'h1);
    for (int i = 0; i < 4; i++) begin
      check("ovf_order", 32'({traceAddress, traceData}), 32'(((16'h0010 + i) << 8) | (i + 1)));
      op(1'b1, 16'h4000, 8'h00, 1'b1);
    end
    check("ovf_drained", 32'(traceValid), 32'h0);
    check("ovf_sticky", 32'(traceOverflow), 32'h1);

    for (int i = 0; i < 3; i++) op(1'b0, 16'(16'h0030 + i), 8'h99, 1'b0);
    set_bus(1'b1, 16'h4000, 8'h00, 1'b0);
    #2 nrst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(traceValid), 32'h0);
    check("mid_rst_rd", 32'(busDataToCpu), 32'h00);
    check("mid_rst_ovf", 32'(traceOverflow), 32'h0);
    @(negedge clk);
    #2 nrst = 1'b1;
    @(negedge clk);
    op(1'b1, 16'h0000, 8'h00, 1'b0);
    check("ram_kept0", 32'(busDataToCpu), 32'hA9);
    op(1'b1, 16'h0001, 8'h00, 1'b0);
    check("ram_kept1", 32'(busDataToCpu), 32'h10);

    for (int i = 0; i < 4; i++) op(1'b0, 16'(16'h0040 + i), 8'(8'hB0 + i), 1'b0);
    op(1'b0, 16'h0020, 8'h77, 1'b1);
    check("full_pp_ovf", 32'(traceOverflow), 32'h0);
    for (int i = 1; i < 4; i++) begin
      check("full_pp_order", 32'({traceAddress, traceData}),
            32'(((16'h0040 + i) << 8) | (8'hB0 + i)));
      op(1'b1, 16'h4000, 8'h00, 1'b1);
    end
    check("full_pp_last", 32'({traceAddress, traceData}), 32'h002077);
    check("full_pp_cnt", 32'(traceValid), 32'h1);
    op(1'b1, 16'h4000, 8'h00, 1'b1);
    check("full_pp_empty", 32'(traceValid), 32'h0);

    // Randomized phase: fill RAM, then mixed traffic with preload collisions.
    for (int i = 0; i < RAM_DEPTH; i++) preload(16'(i), 8'($urandom));
    for (int n = 0; n < 3000; n++) begin : rand_cycle
      logic [15:0] addr;
      int          sel;
      sel = $urandom_range(0, 9);
      if (sel < 5)       addr = 16'($urandom_range(0, RAM_DEPTH - 1));
      else if (sel == 5) addr = 16'(RAM_DEPTH - 1 + $urandom_range(0, 1));
      else if (sel == 6) addr = 16'(16'hFFFA + $urandom_range(0, 5));
      else               addr = 16'($urandom);
      set_bus($urandom_range(0, 2) != 0, addr, 8'($urandom), $urandom_range(0, 4) < 2);
      if ($urandom_range(0, 4) == 0) begin
        loadEnable  = 1'b1;
        loadAddress = $urandom_range(0, 1) ? addr : 16'($urandom_range(0, RAM_DEPTH + 15));
        loadData    = 8'($urandom);
      end
      @(negedge clk);
    end

    check_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
